// File: rtl/reset_sequencer.sv
// Board reset sequencer: settles the external reset, manages the PLL reset and
// lock, then releases each downstream domain reset in a staggered order.
module reset_sequencer #(
    parameter int NUM_DOMAINS           = 3,
    parameter int EXT_RST_SETTLE_CLOCKS = 32,
    parameter int LOCK_SETTLE_CLOCKS    = 16,
    parameter int STAGGER_CLOCKS        = 8,
    parameter int LOCK_TIMEOUT_CLOCKS   = 4096,
    parameter int PLL_RST_CLOCKS        = 8,
    parameter int SW_RST_CLOCKS         = 64,
    parameter int SYNC_STAGES           = 2
) (
    input  logic                   ext_clk_100_in,
    input  logic                   ext_rst_low_in,
    input  logic                   pll_locked_in,
    input  logic [NUM_DOMAINS-1:0] dom_clk_in,
    input  logic                   sw_rst_req_in,
    output logic                   pll_rst_low_out,
    output logic [NUM_DOMAINS-1:0] dom_rst_low_out,
    output logic [2:0]             state_out,
    output logic                   all_released_out,
    output logic [7:0]             lock_loss_cnt_out
);

    localparam int M0 = (EXT_RST_SETTLE_CLOCKS > LOCK_SETTLE_CLOCKS) ?
                        EXT_RST_SETTLE_CLOCKS : LOCK_SETTLE_CLOCKS;
    localparam int M1 = (M0 > STAGGER_CLOCKS) ? M0 : STAGGER_CLOCKS;
    localparam int M2 = (M1 > LOCK_TIMEOUT_CLOCKS) ? M1 : LOCK_TIMEOUT_CLOCKS;
    localparam int M3 = (M2 > PLL_RST_CLOCKS) ? M2 : PLL_RST_CLOCKS;
    localparam int MAXP = (M3 > SW_RST_CLOCKS) ? M3 : SW_RST_CLOCKS;
    localparam int CW = $clog2(MAXP) + 1;
    localparam int IW = $clog2(NUM_DOMAINS) + 1;

    localparam logic [CW-1:0] EXT_TC = CW'(EXT_RST_SETTLE_CLOCKS - 1);
    localparam logic [CW-1:0] LS_TC  = CW'(LOCK_SETTLE_CLOCKS - 1);
    localparam logic [CW-1:0] ST_TC  = CW'(STAGGER_CLOCKS - 1);
    localparam logic [CW-1:0] TO_TC  = CW'(LOCK_TIMEOUT_CLOCKS - 1);
    localparam logic [CW-1:0] PR_TC  = CW'(PLL_RST_CLOCKS - 1);
    localparam logic [CW-1:0] SW_TC  = CW'(SW_RST_CLOCKS - 1);
    localparam logic [IW-1:0] LAST   = IW'(NUM_DOMAINS - 1);

    typedef enum logic [2:0] {
        S_EXT_SETTLE  = 3'd0,
        S_PLL_WAIT    = 3'd1,
        S_LOCK_SETTLE = 3'd2,
        S_RELEASE     = 3'd3,
        S_RUN         = 3'd4,
        S_SW_HOLD     = 3'd5,
        S_PLL_RESET   = 3'd6
    } state_t;

    state_t                 state, state_n;
    logic [CW-1:0]          cnt, cnt_n;
    logic [IW-1:0]          idx, idx_n, idx_inc;
    logic [NUM_DOMAINS-1:0] req_low, req_n;
    logic                   pll_rst, pll_n;
    logic [7:0]             lost_cnt, lost_n, lost_inc;
    logic [1:0]             lock_ff;
    logic                   lock_s;

    assign lock_s   = lock_ff[1];
    assign idx_inc  = idx + IW'(1);
    assign lost_inc = (lost_cnt == 8'hFF) ? lost_cnt : lost_cnt + 8'd1;

    always_ff @(posedge ext_clk_100_in or negedge ext_rst_low_in) begin
        if (!ext_rst_low_in) begin
            lock_ff  <= '0;
            state    <= S_EXT_SETTLE;
            cnt      <= '0;
            idx      <= '0;
            req_low  <= '0;
            pll_rst  <= 1'b0;
            lost_cnt <= '0;
        end else begin
            lock_ff  <= {lock_ff[0], pll_locked_in};
            state    <= state_n;
            cnt      <= cnt_n;
            idx      <= idx_n;
            req_low  <= req_n;
            pll_rst  <= pll_n;
            lost_cnt <= lost_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        req_n   = req_low;
        pll_n   = pll_rst;
        lost_n  = lost_cnt;
        unique case (state)
            S_EXT_SETTLE: begin
                if (cnt == EXT_TC) begin
                    pll_n   = 1'b1;
                    cnt_n   = '0;
                    state_n = S_PLL_WAIT;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_PLL_WAIT: begin
                if (lock_s) begin
                    cnt_n   = '0;
                    state_n = S_LOCK_SETTLE;
                end else if (cnt == TO_TC) begin
                    pll_n   = 1'b0;
                    cnt_n   = '0;
                    state_n = S_PLL_RESET;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_PLL_RESET: begin
                if (cnt == PR_TC) begin
                    pll_n   = 1'b1;
                    cnt_n   = '0;
                    state_n = S_PLL_WAIT;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_LOCK_SETTLE: begin
                if (!lock_s) begin
                    cnt_n   = '0;
                    state_n = S_PLL_WAIT;
                end else if (cnt == LS_TC) begin
                    req_n    = '0;
                    req_n[0] = 1'b1;
                    idx_n    = '0;
                    cnt_n    = '0;
                    state_n  = S_RELEASE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_RELEASE: begin
                if (!lock_s) begin
                    req_n   = '0;
                    lost_n  = lost_inc;
                    cnt_n   = '0;
                    state_n = S_PLL_WAIT;
                end else if (cnt == ST_TC) begin
                    cnt_n = '0;
                    if (idx == LAST) begin
                        state_n = S_RUN;
                    end else begin
                        idx_n = idx_inc;
                        for (int i = 0; i < NUM_DOMAINS; i++)
                            if (IW'(i) == idx_inc) req_n[i] = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_RUN: begin
                // Lock loss outranks a simultaneous software request.
                if (!lock_s) begin
                    req_n   = '0;
                    lost_n  = lost_inc;
                    cnt_n   = '0;
                    state_n = S_PLL_WAIT;
                end else if (sw_rst_req_in) begin
                    req_n   = '0;
                    cnt_n   = '0;
                    state_n = S_SW_HOLD;
                end
            end
            S_SW_HOLD: begin
                if (!lock_s) begin
                    req_n   = '0;
                    cnt_n   = '0;
                    state_n = S_PLL_WAIT;
                end else if (cnt == SW_TC) begin
                    req_n    = '0;
                    req_n[0] = 1'b1;
                    idx_n    = '0;
                    cnt_n    = '0;
                    state_n  = S_RELEASE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = S_EXT_SETTLE;
            end
        endcase
    end

    for (genvar g = 0; g < NUM_DOMAINS; g++) begin : g_sync
        logic [SYNC_STAGES-1:0] chain;
        logic                   clr_n;
        assign clr_n = req_low[g] & ext_rst_low_in;
        always_ff @(posedge dom_clk_in[g] or negedge clr_n) begin
            if (!clr_n) chain <= '0;
            else        chain <= {chain[SYNC_STAGES-2:0], 1'b1};
        end
        assign dom_rst_low_out[g] = chain[SYNC_STAGES-1];
    end

    assign pll_rst_low_out   = pll_rst;
    assign state_out         = state;
    assign all_released_out  = (state == S_RUN);
    assign lock_loss_cnt_out = lost_cnt;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: vector table for the main power-up,
// software reset and lock-loss flow, plus hand sequences for the corner cases.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lock = 1'b0;
    logic       sw = 1'b0;
    logic [2:0] dom_clk = 3'b000;
    logic       pll_rst_n;
    logic [2:0] dom_rst_n;
    logic [2:0] st;
    logic       all_rel;
    logic [7:0] lost;

    int n_tests = 0;
    int n_fail = 0;

    reset_sequencer dut (
        .ext_clk_100_in   (clk),
        .ext_rst_low_in   (rst_n),
        .pll_locked_in    (lock),
        .dom_clk_in       (dom_clk),
        .sw_rst_req_in    (sw),
        .pll_rst_low_out  (pll_rst_n),
        .dom_rst_low_out  (dom_rst_n),
        .state_out        (st),
        .all_released_out (all_rel),
        .lock_loss_cnt_out(lost)
    );

    always #5 clk = ~clk;
    initial begin
        #2;
        forever #5 dom_clk = ~dom_clk;
    end

    typedef struct {
        string      name;
        int         n;
        logic       lock;
        logic       sw;
        logic [2:0] st;
        logic       pll;
        logic [2:0] dom;
        logic       all;
        logic [7:0] cnt;
    } vec_t;

    vec_t vt[$];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input logic [2:0] e_st,
                           input logic e_pll, input logic [2:0] e_dom,
                           input logic e_all, input logic [7:0] e_cnt);
        n_tests++;
        if ({st, pll_rst_n, dom_rst_n, all_rel, lost} !==
            {e_st, e_pll, e_dom, e_all, e_cnt}) begin
            n_fail++;
            $display("FAIL %s: got st=%0d pll=%b dom=%b all=%b cnt=%0d, want st=%0d pll=%b dom=%b all=%b cnt=%0d",
                     name, st, pll_rst_n, dom_rst_n, all_rel, lost,
                     e_st, e_pll, e_dom, e_all, e_cnt);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget,
                              output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            step(1);
            if (st == s) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset(input string name);
        rst_n = 1'b0;
        #1;
        chk_out({name, "_async"}, 3'd0, 1'b0, 3'b000, 1'b0, 8'd0);
        step(3);
        chk_out({name, "_held"}, 3'd0, 1'b0, 3'b000, 1'b0, 8'd0);
        rst_n = 1'b1;
    endtask

    task automatic add(input string name, input int n, input logic lk,
                       input logic s, input logic [2:0] e_st,
                       input logic e_pll, input logic [2:0] e_dom,
                       input logic e_all, input logic [7:0] e_cnt);
        vec_t v;
        v.name = name; v.n = n; v.lock = lk; v.sw = s;
        v.st = e_st; v.pll = e_pll; v.dom = e_dom; v.all = e_all; v.cnt = e_cnt;
        vt.push_back(v);
    endtask

    initial begin
        bit ok;

        // Edge numbers in names count rising edges after reset release.
        add("settle_e31",     31, 0, 0, 3'd0, 0, 3'b000, 0, 8'd0);
        add("pll_rel_e32",     1, 0, 0, 3'd1, 1, 3'b000, 0, 8'd0);
        add("pll_wait_e100",  68, 0, 0, 3'd1, 1, 3'b000, 0, 8'd0);
        add("lock_sync_e102",  2, 1, 0, 3'd1, 1, 3'b000, 0, 8'd0);
        add("lk_settle_e103",  1, 1, 0, 3'd2, 1, 3'b000, 0, 8'd0);
        add("lk_settle_e118", 15, 1, 0, 3'd2, 1, 3'b000, 0, 8'd0);
        add("release_e119",    1, 1, 0, 3'd3, 1, 3'b000, 0, 8'd0);
        add("sync0_e120",      1, 1, 0, 3'd3, 1, 3'b000, 0, 8'd0);
        add("sync0_e121",      1, 1, 0, 3'd3, 1, 3'b001, 0, 8'd0);
        add("stag_e127",       6, 1, 0, 3'd3, 1, 3'b001, 0, 8'd0);
        add("sync1_e128",      1, 1, 0, 3'd3, 1, 3'b001, 0, 8'd0);
        add("sync1_e129",      1, 1, 0, 3'd3, 1, 3'b011, 0, 8'd0);
        add("sync2_e137",      8, 1, 0, 3'd3, 1, 3'b111, 0, 8'd0);
        add("pre_run_e142",    5, 1, 0, 3'd3, 1, 3'b111, 0, 8'd0);
        add("run_e143",        1, 1, 0, 3'd4, 1, 3'b111, 1, 8'd0);
        add("sw_req_e144",     1, 1, 1, 3'd5, 1, 3'b000, 0, 8'd0);
        add("sw_hold_e207",   63, 1, 0, 3'd5, 1, 3'b000, 0, 8'd0);
        add("sw_rel_e208",     1, 1, 0, 3'd3, 1, 3'b000, 0, 8'd0);
        add("sw_stag_e216",    8, 1, 0, 3'd3, 1, 3'b001, 0, 8'd0);
        add("sw_in_rel_e217",  1, 1, 1, 3'd3, 1, 3'b001, 0, 8'd0);
        add("sw_ign_e218",     1, 1, 0, 3'd3, 1, 3'b011, 0, 8'd0);
        add("sw_stag_e224",    6, 1, 0, 3'd3, 1, 3'b011, 0, 8'd0);
        add("sw_run_e232",     8, 1, 0, 3'd4, 1, 3'b111, 1, 8'd0);
        add("drop_sync_e234",  2, 0, 0, 3'd4, 1, 3'b111, 1, 8'd0);
        add("drop_e235",       1, 0, 0, 3'd1, 1, 3'b000, 0, 8'd1);
        add("relock_e237",     2, 1, 0, 3'd1, 1, 3'b000, 0, 8'd1);
        add("relock_e238",     1, 1, 0, 3'd2, 1, 3'b000, 0, 8'd1);
        add("settle10_e248",  10, 1, 0, 3'd2, 1, 3'b000, 0, 8'd1);
        add("glitch_e249",     1, 0, 0, 3'd2, 1, 3'b000, 0, 8'd1);
        add("glitch_e251",     2, 1, 0, 3'd1, 1, 3'b000, 0, 8'd1);
        add("resettle_e252",   1, 1, 0, 3'd2, 1, 3'b000, 0, 8'd1);
        add("resettle_e267",  15, 1, 0, 3'd2, 1, 3'b000, 0, 8'd1);
        add("rerel_e268",      1, 1, 0, 3'd3, 1, 3'b000, 0, 8'd1);
        add("rerun_e292",     24, 1, 0, 3'd4, 1, 3'b111, 1, 8'd1);

        step(2);
        do_reset("por");
        foreach (vt[i]) begin
            lock = vt[i].lock;
            sw   = vt[i].sw;
            step(vt[i].n);
            chk_out(vt[i].name, vt[i].st, vt[i].pll, vt[i].dom,
                    vt[i].all, vt[i].cnt);
        end

        // 300 lock drops from RUN/RELEASE: counter saturates at 255.
        ok = 1'b1;
        for (int d = 0; d < 300 && ok; d++) begin
            if (d > 0) wait_state(3'd3, 100, ok);
            lock = 1'b0;
            if (ok) wait_state(3'd1, 10, ok);
            lock = 1'b1;
            if (d == 0) chk_out("drop_cnt2", 3'd1, 1, 3'b000, 0, 8'd2);
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL sat_loop: state wait timed out, st=%0d", st);
        end
        wait_state(3'd4, 200, ok);
        chk_out("sat_255_run", 3'd4, 1, 3'b111, 1, 8'd255);

        // Lock never arrives: PLL re-reset pulses of 8 every 4096+8 cycles.
        lock = 1'b0;
        do_reset("rst2");
        step(4127);
        chk_out("to_wait_e4127", 3'd1, 1, 3'b000, 0, 8'd0);
        step(1);
        chk_out("to_prst_e4128", 3'd6, 0, 3'b000, 0, 8'd0);
        step(7);
        chk_out("to_prst_e4135", 3'd6, 0, 3'b000, 0, 8'd0);
        step(1);
        chk_out("to_wait_e4136", 3'd1, 1, 3'b000, 0, 8'd0);
        step(4095);
        chk_out("to_wait_e8231", 3'd1, 1, 3'b000, 0, 8'd0);
        step(1);
        chk_out("to_prst_e8232", 3'd6, 0, 3'b000, 0, 8'd0);

        // External reset mid-RELEASE at idx 1, then full sequence again.
        lock = 1'b1;
        do_reset("rst3");
        step(48);
        chk_out("fast_lk_e48", 3'd2, 1, 3'b000, 0, 8'd0);
        step(1);
        chk_out("fast_rel_e49", 3'd3, 1, 3'b000, 0, 8'd0);
        step(11);
        chk_out("idx1_e60", 3'd3, 1, 3'b011, 0, 8'd0);
        do_reset("mid_rel");
        step(49);
        chk_out("again_rel_e49", 3'd3, 1, 3'b000, 0, 8'd0);
        step(24);
        chk_out("again_run_e73", 3'd4, 1, 3'b111, 1, 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
